// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch front end
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef logic [11:0] pc_t;

  typedef struct packed {
    logic [31:0] instr;
    pc_t         pc;
  } fetch_entry_t;

  localparam pc_t PC_STEP       = 12'd4;
  localparam int  FETCH_Q_DEPTH = 2;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : 2-entry FIFO of fetched words with synchronous flush
// Revision    : 1.0
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  fetch_entry_t r_head;
  fetch_entry_t r_tail;
  logic [1:0]   r_count;

  // Flush only clears the count; the head data is kept so the outputs hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (i_push) begin
            r_head  <= i_entry;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (i_push && i_pop) begin
            r_head <= i_entry;
          end else if (i_push) begin
            r_tail  <= i_entry;
            r_count <= 2'd2;
          end else if (i_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_entry;
            end else begin
              r_count <= 2'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && !i_flush && (r_count == 2'(FETCH_Q_DEPTH))));
`endif

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : fetch PC, ROM read issue, PC tagging and 2-deep word queue
// Revision    : 1.0
// ============================================================================
module instr_fetch
  import fetch_pkg::*;
#(
  parameter pc_t RESET_PC = 12'h000
)
(
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [11:0] rom_addr_out,
  input  logic [31:0] rom_instr_in,
  input  logic        redirect_valid_in,
  input  logic [11:0] redirect_pc_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [11:0] pc_out,
  input  logic        instr_ready_in
);

  pc_t          r_fetch_pc;
  pc_t          r_inflight_pc;
  logic         r_inflight;

  logic         w_pop;
  logic         w_push;
  logic         w_issue;
  logic [2:0]   w_outstanding;
  logic [1:0]   w_q_count;
  logic         w_q_valid;
  fetch_entry_t w_q_head;
  fetch_entry_t w_capture;

  // Credit: queued + in flight, less what decode takes now, must leave a slot.
  assign w_pop         = w_q_valid && instr_ready_in;
  assign w_outstanding = {1'b0, w_q_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue       = !redirect_valid_in && (w_outstanding < 3'(FETCH_Q_DEPTH));
  assign w_push        = r_inflight && !redirect_valid_in;
  assign w_capture     = '{instr: rom_instr_in, pc: r_inflight_pc};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
    end else if (redirect_valid_in) begin
      r_fetch_pc <= {redirect_pc_in[11:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_inflight_pc <= r_fetch_pc;
      r_fetch_pc    <= r_fetch_pc + PC_STEP;
      r_inflight    <= 1'b1;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_queue u_fetch_queue (
    .clk     (clk_in),
    .rst     (rst_in),
    .i_flush (redirect_valid_in),
    .i_push  (w_push),
    .i_entry (w_capture),
    .i_pop   (w_pop),
    .o_head  (w_q_head),
    .o_valid (w_q_valid),
    .o_count (w_q_count)
  );

  assign rom_addr_out    = r_fetch_pc;
  assign instr_valid_out = w_q_valid;
  assign instr_out       = w_q_head.instr;
  assign pc_out          = w_q_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch : randomized and directed bench against a stream-level model
// Revision       : 1.0
// ============================================================================
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam pc_t RESET_A = 12'h100;
  localparam pc_t RESET_B = 12'hFF8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        ready;

  logic [11:0] addr_a, pc_a, addr_b, pc_b;
  logic [31:0] rom_a, rom_b, instr_a, instr_b;
  logic        valid_a, valid_b;

  logic [31:0] mem [0:1023];

  always @(posedge clk) begin
    rom_a <= mem[addr_a[11:2]];
    rom_b <= mem[addr_b[11:2]];
  end

  instr_fetch #(.RESET_PC(RESET_A)) dut_a (
    .clk_in            (clk),
    .rst_in            (rst),
    .rom_addr_out      (addr_a),
    .rom_instr_in      (rom_a),
    .redirect_valid_in (redirect_valid),
    .redirect_pc_in    (redirect_pc),
    .instr_valid_out   (valid_a),
    .instr_out         (instr_a),
    .pc_out            (pc_a),
    .instr_ready_in    (ready)
  );

  // Second instance exercises the address wrap from the top of the ROM.
  instr_fetch #(.RESET_PC(RESET_B)) dut_b (
    .clk_in            (clk),
    .rst_in            (rst),
    .rom_addr_out      (addr_b),
    .rom_instr_in      (rom_b),
    .redirect_valid_in (1'b0),
    .redirect_pc_in    (12'h000),
    .instr_valid_out   (valid_b),
    .instr_out         (instr_b),
    .pc_out            (pc_b),
    .instr_ready_in    (1'b1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;

  // Model: the accepted stream is consecutive PCs from the last restart;
  // e counts edges since the restart (saturating at 3).
  int          e_a = 0;
  int          e_b = 0;
  pc_t         exp_a = '0;
  pc_t         exp_b = '0;
  pc_t         hold_pc = '0;
  logic [31:0] hold_instr = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s t=%0t actual=%h expected=%h", tag, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic n_rst, input logic n_red, input logic [11:0] n_pc,
                       input logic n_rdy);
    pc_t exp_addr;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_a      = RESET_A;
      e_a        = 1;
      hold_pc    = '0;
      hold_instr = '0;
      exp_b      = RESET_B;
      e_b        = 1;
    end else begin
      if (e_a >= 3 && ready) exp_a = exp_a + PC_STEP;
      if (redirect_valid) begin
        exp_a = {redirect_pc[11:2], 2'b00};
        e_a   = 1;
      end else if (e_a < 3) begin
        e_a++;
      end
      if (e_b >= 3) exp_b = exp_b + PC_STEP;
      if (e_b < 3) e_b++;
    end

    check_eq("a_valid", 32'(valid_a), 32'(e_a >= 3));
    exp_addr = exp_a + 12'(4 * (e_a - 1));
    check_eq("a_rom_addr", 32'(addr_a), 32'(exp_addr));
    if (e_a >= 3) begin
      hold_pc    = exp_a;
      hold_instr = mem[exp_a[11:2]];
    end
    check_eq("a_pc", 32'(pc_a), 32'(hold_pc));
    check_eq("a_instr", instr_a, hold_instr);

    check_eq("b_valid", 32'(valid_b), 32'(e_b >= 3));
    exp_addr = exp_b + 12'(4 * (e_b - 1));
    check_eq("b_rom_addr", 32'(addr_b), 32'(exp_addr));
    if (e_b >= 3) begin
      check_eq("b_pc", 32'(pc_b), 32'(exp_b));
      check_eq("b_instr", instr_b, mem[exp_b[11:2]]);
    end

    rst            = n_rst;
    redirect_valid = n_red;
    redirect_pc    = n_pc;
    ready          = n_rdy;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 12'h000;
    ready          = 1'b1;

    // Reset and free-running stream
    cycle(1'b1, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Backpressure mid-stream
    repeat (5) cycle(1'b0, 1'b0, 12'h000, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Redirect with the queue full
    repeat (3) cycle(1'b0, 1'b0, 12'h000, 1'b0);
    cycle(1'b0, 1'b1, 12'h203, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Redirect coinciding with an accepted head
    cycle(1'b0, 1'b1, 12'h3A0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Back-to-back redirects
    cycle(1'b0, 1'b1, 12'h040, 1'b1);
    cycle(1'b0, 1'b1, 12'h7FE, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Reset mid-stream with queue full and a redirect pending
    repeat (3) cycle(1'b0, 1'b0, 12'h000, 1'b0);
    cycle(1'b1, 1'b1, 12'h500, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 15) == 0),
            12'($urandom_range(0, 4095)),
            ($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, 1'b0, 12'h000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the RISC-V core; the initiator side of the synchronous instruction ROM interface. It holds the fetch PC, drives the ROM byte address, and tags each ROM word with its PC. It buffers words in a 2-entry queue so the one-cycle ROM read latency survives downstream stalls. It sits between `instr_rom` and the decode stage, and accepts PC redirects from branch/jump resolution.

## Interface
- `RESET_PC`, 12'h000, byte address of the first fetch after reset; bits [1:0] must be 0.
- `clk_in`  input  1  single clock; the ROM uses the same clock.
- `rst_in`  input  1  reset, synchronous and active-high.
- `rom_addr_out`  output  12  byte address to the ROM; the ROM uses bits [11:2].
- `rom_instr_in`  input  32  ROM data; valid one cycle after the address is presented.
- `redirect_valid_in`  input  1  one-cycle pulse: flush and restart fetch at `redirect_pc_in`.
- `redirect_pc_in`  input  12  redirect target; bits [1:0] are ignored and treated as 0.
- `instr_valid_out`  output  1  queue head is valid.
- `instr_out`  output  32  instruction at the queue head.
- `pc_out`  output  12  byte PC of `instr_out`.
- `instr_ready_in`  input  1  decode accepts the head this cycle.

## Operation
- `rom_addr_out` is driven directly from the `fetch_pc` register. The ROM samples it every cycle; only issued reads are captured.
- **Issue**: `issue = !redirect_valid_in && (count + inflight - pop) < 2`, where `pop = instr_valid_out && instr_ready_in`.
  - On issue: `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`, `inflight <= 1`.
  - Without issue: `inflight <= 0`.
- **Capture**: if `inflight` is set and there is no redirect, {`rom_instr_in`, `inflight_pc`} is pushed into the queue this cycle.
- **Queue**: 2 entries, FIFO order.
  - Push and pop in the same cycle are both honoured.
  - The credit rule guarantees no push when full; overflow is unreachable and is asserted against in simulation.
- **Redirect** (`redirect_valid_in` = 1):
  - queue flushed;
  - `inflight <= 0`, so the in-flight word is discarded;
  - `fetch_pc <= {redirect_pc_in[11:2], 2'b00}`;
  - no issue that cycle.
- Redirect coinciding with pop: the pop counts as accepted by decode, and the flush still applies to everything else.
- Back-to-back redirects: the last one wins; each flushes again.
- PC arithmetic is modulo 4096. After 12'hFFC the next fetch is 12'h000; no error.
- Reset wins over redirect and handshake in the same cycle.
- No internal state machine beyond the `inflight` flag, the queue count (0..2) and the PC registers.

## Timing
- Reset values:
  - `fetch_pc` = `RESET_PC`, so `rom_addr_out` = `RESET_PC`;
  - `inflight` = 0, `count` = 0;
  - `instr_valid_out` = 0, `instr_out` = 32'h0, `pc_out` = 12'h0.
- `instr_out` and `pc_out` hold their last value while the queue is empty; the head register is cleared only by reset.
- Start-up latency. Let C0 be the first cycle with `rst_in` low:
  - C0: issue at `RESET_PC`;
  - C1: capture;
  - C2: `instr_valid_out` = 1 with `pc_out` = `RESET_PC`.
- Redirect latency: redirect in cycle N → issue at N+1 → `instr_valid_out` at N+3 with the target PC. During N+1..N+2, `instr_valid_out` = 0.
- Steady state with `instr_ready_in` held at 1: one instruction per cycle, consecutive PCs, no bubbles.
- Stall: with `instr_ready_in` = 0, at most 2 words are outstanding (queued + in flight), after which issue halts. When ready is released, the stream resumes with no lost or duplicated PC.
- All outputs are registered or driven from registers. There is no combinational path from any input to `rom_addr_out`, `instr_valid_out`, `instr_out` or `pc_out`.

## Structure
- Package `fetch_pkg`:
  - `typedef logic [11:0] pc_t`;
  - `typedef struct packed {logic [31:0] instr; pc_t pc;} fetch_entry_t`;
  - constants `PC_STEP = 4` and `FETCH_Q_DEPTH = 2`.
- Sub-module `fetch_queue`: 2-entry FIFO of `fetch_entry_t` with synchronous flush, push/pop, a `count` output and a simulation-only overflow assertion.
- `instr_fetch` contains the PC and in-flight logic, the credit rule, and the `fetch_queue` instance.

## Test plan
- **Reset and stream**: `RESET_PC` = 12'h100, ROM holds `mem[i] = i`, `instr_ready_in` = 1. Required: valid from C2 with PCs 100, 104, 108… and instrs 0x40, 0x41, 0x42…, one per cycle.
- **Backpressure**: hold ready low for 5 cycles mid-stream. Required: `rom_addr_out` stalls with ≤2 words outstanding; no PC is skipped or repeated after release.
- **Redirect**: pulse redirect to 12'h203 while the queue is full. Required: valid drops for 2 cycles, then PC 12'h200 with `mem[0x80]`, then 12'h204.
- **Redirect with pop**: redirect coincides with an accepted head. Required: that head is consumed once; the next valid PC is the target.
- **Wrap**: `RESET_PC` = 12'hFF8. Required: PCs FF8, FFC, 000, 004.
- **Reset mid-stream**: assert `rst_in` for 1 cycle with the queue full and a redirect pending. Required: all outputs return to reset values; the stream restarts at `RESET_PC` 2 cycles after release.
